core_run_controller: RTL and testbench

Execution sequencer for the 8-bit single-cycle core. It decides, cycle by cycle, whether the core may commit the instruction at its current PC, and supports run, single-step, user halt, a PC breakpoint and self-jump (jump-to-self) detection. It sits between the board controls and the core's clock-enable input, observes the core's PC and instruction bus, and exposes run status and a retired-instruction count for the 7-segment console.

---
 rtl/core_run_controller_if.sv | 46 ++++
 rtl/core_run_controller.sv | 143 ++++++++++++++
 tb/tb_core_run_controller.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_run_controller_if.sv
// core_run_controller_if
//
// Bundles the run controller's board controls, the core observation bus and
// the console status outputs into one interface.
//
// Signals:
//   run_start   - one-cycle pulse, start free-running execution
//   step        - one-cycle pulse, execute exactly one instruction
//   halt        - level or pulse, stop execution
//   bp_enable   - breakpoint armed
//   bp_addr     - breakpoint PC
//   pc          - core's current instruction address
//   instruction - instruction at pc
//   core_enable - core commits the instruction at pc at the end of this cycle
//   state       - 00 IDLE, 01 RUN, 10 STEP, 11 HALTED
//   halt_cause  - 00 none, 01 user halt, 10 breakpoint, 11 self-jump
//   retired     - saturating count of committed instructions
//
// Modports:
//   master - the side driving controls and the core bus (board / testbench)
//   slave  - the run controller itself
interface core_run_controller_if #(
    parameter int RETIRE_WIDTH = 16
);
    logic                    run_start;
    logic                    step;
    logic                    halt;
    logic                    bp_enable;
    logic [7:0]              bp_addr;
    logic [7:0]              pc;
    logic [7:0]              instruction;
    logic                    core_enable;
    logic [1:0]              state;
    logic [1:0]              halt_cause;
    logic [RETIRE_WIDTH-1:0] retired;

    modport master (
        output run_start, step, halt, bp_enable, bp_addr, pc, instruction,
        input  core_enable, state, halt_cause, retired
    );

    modport slave (
        input  run_start, step, halt, bp_enable, bp_addr, pc, instruction,
        output core_enable, state, halt_cause, retired
    );
endinterface

// File: rtl/core_run_controller.sv
// core_run_controller
//
// Execution sequencer for the 8-bit single-cycle core. Decides each cycle
// whether the core may commit the instruction at its current PC. Supports
// free run, single step, user halt, a PC breakpoint and self-jump detection,
// and keeps a saturating retired-instruction count for the console.
//
// Ports:
//   clock - system clock, shared with the core
//   reset - asynchronous, active-high
//   ctl   - core_run_controller_if slave modport (controls, core bus, status)
//
// Parameters:
//   RETIRE_WIDTH - width of the retired-instruction counter
module core_run_controller #(
    parameter int RETIRE_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    core_run_controller_if.slave  ctl
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_USER   = 2'b01,
        CAUSE_BP     = 2'b10,
        CAUSE_SELFJ  = 2'b11
    } cause_e;

    state_e                  state_q, state_d;
    cause_e                  cause_q, cause_d;
    logic [RETIRE_WIDTH-1:0] retired_q, retired_d;
    logic                    skip_bp_q, skip_bp_d;

    logic self_jump;
    logic bp_hit;
    logic commit_ok;
    logic core_enable;
    logic unused_opcode_bits;

    // Only the opcode and the immediate low bits matter for self-jump.
    assign unused_opcode_bits = ^ctl.instruction[5:2];

    // A jump with immediate -1 targets its own pc. skip_bp masks the
    // breakpoint for the first commit after a (re)start so resuming from a
    // breakpoint executes that instruction rather than re-halting on it.
    always_comb begin
        self_jump = (ctl.instruction[7:6] == 2'b11) && (ctl.instruction[1:0] == 2'b11);
        bp_hit    = ctl.bp_enable && (ctl.pc == ctl.bp_addr) && !skip_bp_q;
    end

    // Commit permission; reset gates it directly so it drops asynchronously.
    always_comb begin
        commit_ok = 1'b0;
        case (state_q)
            ST_RUN:  commit_ok = !ctl.halt && !bp_hit && !self_jump;
            ST_STEP: commit_ok = !ctl.halt;
            default: commit_ok = 1'b0;
        endcase
        core_enable = commit_ok && !reset;
    end

    // Next-state logic. halt wins in every state; run_start beats step.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        skip_bp_d = skip_bp_q;
        retired_d = retired_q;

        if (core_enable) begin
            skip_bp_d = 1'b0;
            if (retired_q != {RETIRE_WIDTH{1'b1}}) begin
                retired_d = retired_q + RETIRE_WIDTH'(1);
            end
        end

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (ctl.halt) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_USER;
                end else if (ctl.run_start) begin
                    state_d   = ST_RUN;
                    cause_d   = CAUSE_NONE;
                    skip_bp_d = 1'b1;
                end else if (ctl.step) begin
                    state_d   = ST_STEP;
                    cause_d   = CAUSE_NONE;
                    skip_bp_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (ctl.halt) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_USER;
                end else if (bp_hit) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_BP;
                end else if (self_jump) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_SELFJ;
                end
            end
            ST_STEP: begin
                if (ctl.halt) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_USER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cause_q   <= CAUSE_NONE;
            retired_q <= '0;
            skip_bp_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
            skip_bp_q <= skip_bp_d;
        end
    end

    assign ctl.core_enable = core_enable;
    assign ctl.state       = state_q;
    assign ctl.halt_cause  = cause_q;
    assign ctl.retired     = retired_q;

endmodule

// File: tb/tb_core_run_controller.sv
// tb_core_run_controller
//
// Drives two controllers (16-bit and 4-bit retired counters) from the same
// stimulus, acting as the core itself: pc advances by one on every commit the
// reference model predicts, or stays put on a self-jump. Outputs are compared
// each cycle against a behavioural model written from the operating rules.
module tb_core_run_controller;

    logic clock;
    logic reset;

    core_run_controller_if #(.RETIRE_WIDTH(16)) bus16 ();
    core_run_controller_if #(.RETIRE_WIDTH(4))  bus4 ();

    core_run_controller #(.RETIRE_WIDTH(16)) dut16 (
        .clock (clock),
        .reset (reset),
        .ctl   (bus16)
    );

    core_run_controller #(.RETIRE_WIDTH(4)) dut4 (
        .clock (clock),
        .reset (reset),
        .ctl   (bus4)
    );

    // The narrow instance sees exactly the same inputs as the wide one.
    assign bus4.run_start   = bus16.run_start;
    assign bus4.step        = bus16.step;
    assign bus4.halt        = bus16.halt;
    assign bus4.bp_enable   = bus16.bp_enable;
    assign bus4.bp_addr     = bus16.bp_addr;
    assign bus4.pc          = bus16.pc;
    assign bus4.instruction = bus16.instruction;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [256];
    logic [7:0] core_pc;

    // Reference model: plain flags and an unbounded commit count.
    bit m_running;
    bit m_stepping;
    bit m_halted;
    int m_cause;
    int m_count;
    bit m_skip;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int satCount(input int count, input int width);
        int limit;
        limit = (1 << width) - 1;
        return (count > limit) ? limit : count;
    endfunction

    task automatic modelReset();
        m_running  = 0;
        m_stepping = 0;
        m_halted   = 0;
        m_cause    = 0;
        m_count    = 0;
        m_skip     = 0;
        core_pc    = 8'h00;
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic applyStimulus(input bit rs, input bit st, input bit hl);
        logic [7:0] ins;
        bit sj, hit, exp_en;
        int exp_state;

        ins = mem[core_pc];
        bus16.run_start   = rs;
        bus16.step        = st;
        bus16.halt        = hl;
        bus16.pc          = core_pc;
        bus16.instruction = ins;
        #4;

        sj  = (ins[7:6] == 2'b11) && (ins[1:0] == 2'b11);
        hit = bus16.bp_enable && (core_pc == bus16.bp_addr) && !m_skip;
        exp_en = (m_running && !hl && !hit && !sj) || (m_stepping && !hl);
        exp_state = m_running ? 1 : (m_stepping ? 2 : (m_halted ? 3 : 0));

        checkOutput("core_enable", bus16.core_enable, exp_en);
        checkOutput("core_enable_w4", bus4.core_enable, exp_en);
        checkOutput("state", bus16.state, exp_state);
        checkOutput("halt_cause", bus16.halt_cause, m_cause);
        checkOutput("retired", bus16.retired, satCount(m_count, 16));
        checkOutput("retired_w4", bus4.retired, satCount(m_count, 4));

        if (hl) begin
            m_running  = 0;
            m_stepping = 0;
            m_halted   = 1;
            m_cause    = 1;
        end else if (m_running) begin
            if (hit) begin
                m_running = 0; m_halted = 1; m_cause = 2;
            end else if (sj) begin
                m_running = 0; m_halted = 1; m_cause = 3;
            end
        end else if (m_stepping) begin
            m_stepping = 0;
        end else if (rs) begin
            m_running = 1; m_halted = 0; m_cause = 0; m_skip = 1;
        end else if (st) begin
            m_stepping = 1; m_halted = 0; m_cause = 0; m_skip = 1;
        end

        @(posedge clock);
        #1;
        if (exp_en) begin
            m_count++;
            m_skip = 0;
            if (!sj) core_pc = core_pc + 8'd1;
        end
        bus16.run_start = 1'b0;
        bus16.step      = 1'b0;
        bus16.halt      = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0);
    endtask

    // Reset asserted at posedge+1 for two edges, with reset values checked.
    task automatic doReset();
        reset = 1'b1;
        bus16.run_start = 1'b0;
        bus16.step      = 1'b0;
        bus16.halt      = 1'b0;
        modelReset();
        bus16.pc          = core_pc;
        bus16.instruction = mem[core_pc];
        #2;
        checkOutput("rst_core_enable", bus16.core_enable, 0);
        checkOutput("rst_state", bus16.state, 0);
        checkOutput("rst_halt_cause", bus16.halt_cause, 0);
        checkOutput("rst_retired", bus16.retired, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic fillMem(input logic [7:0] value);
        for (int i = 0; i < 256; i++) mem[i] = value;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        reset           = 1'b1;
        bus16.bp_enable = 1'b0;
        bus16.bp_addr   = 8'h00;
        fillMem(8'h00);
        #1;
        doReset();

        // Straight-line program committed back to back.
        $display("[TB] run of add/add/add/store");
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h40;
        applyStimulus(1, 0, 0);
        checkOutput("tp1_state_run", bus16.state, 1);
        idleCycles(4);
        checkOutput("tp1_retired", bus16.retired, 4);
        applyStimulus(0, 0, 1);

        // Breakpoint at pc 3, then resume through it.
        $display("[TB] breakpoint and resume");
        fillMem(8'h00);
        doReset();
        bus16.bp_enable = 1'b1;
        bus16.bp_addr   = 8'h03;
        applyStimulus(1, 0, 0);
        idleCycles(5);
        checkOutput("tp2_state", bus16.state, 3);
        checkOutput("tp2_cause", bus16.halt_cause, 2);
        checkOutput("tp2_retired", bus16.retired, 3);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("tp2_resume_retired", bus16.retired, 4);
        idleCycles(2);
        bus16.bp_enable = 1'b0;

        // Self-jump at pc 5, then a single step through it.
        $display("[TB] self-jump then step");
        fillMem(8'h00);
        mem[5] = 8'hFF;
        doReset();
        applyStimulus(1, 0, 0);
        idleCycles(7);
        checkOutput("tp3_state", bus16.state, 3);
        checkOutput("tp3_cause", bus16.halt_cause, 3);
        checkOutput("tp3_retired", bus16.retired, 5);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
        checkOutput("tp3_step_state", bus16.state, 0);
        checkOutput("tp3_step_retired", bus16.retired, 6);
        idleCycles(1);

        // Two single steps separated by idle cycles.
        $display("[TB] two steps");
        fillMem(8'h00);
        doReset();
        applyStimulus(0, 1, 0);
        idleCycles(3);
        applyStimulus(0, 1, 0);
        idleCycles(3);
        checkOutput("tp4_retired", bus16.retired, 2);
        checkOutput("tp4_state", bus16.state, 0);

        // halt with run_start, and halt coinciding with a breakpoint.
        $display("[TB] halt priority");
        doReset();
        applyStimulus(1, 0, 1);
        checkOutput("tp5_state", bus16.state, 3);
        checkOutput("tp5_cause", bus16.halt_cause, 1);
        checkOutput("tp5_retired", bus16.retired, 0);
        bus16.bp_enable = 1'b1;
        bus16.bp_addr   = 8'h02;
        applyStimulus(1, 0, 0);
        idleCycles(2);
        applyStimulus(0, 0, 1);
        checkOutput("tp5_bp_halt_cause", bus16.halt_cause, 1);
        bus16.bp_enable = 1'b0;

        // Asynchronous reset in the middle of a run; narrow counter saturates.
        $display("[TB] async reset mid-run");
        doReset();
        applyStimulus(1, 0, 0);
        idleCycles(16);
        checkOutput("tp6_retired", bus16.retired, 16);
        checkOutput("tp6_retired_sat_w4", bus4.retired, 15);
        checkOutput("tp6_running_enable", bus16.core_enable, 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("tp6_async_enable", bus16.core_enable, 0);
        checkOutput("tp6_async_state", bus16.state, 0);
        checkOutput("tp6_async_retired", bus16.retired, 0);
        checkOutput("tp6_async_cause", bus16.halt_cause, 0);
        modelReset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        idleCycles(2);

        // Randomised episodes with random programs, breakpoints and controls.
        $display("[TB] random episodes");
        for (int ep = 0; ep < 4; ep++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            bus16.bp_enable = 1'($urandom_range(0, 1));
            bus16.bp_addr   = 8'($urandom_range(0, 24));
            doReset();
            for (int c = 0; c < 150; c++) begin
                applyStimulus(($urandom % 8) == 0, ($urandom % 10) == 0,
                              ($urandom % 20) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
